// File: rtl/vga_scanout.sv
// vga_scanout: 160x120x3 framebuffer scanned out as 640x480 VGA with 4x4 pixels.
// Define SCANOUT_CLEAR_EN to fill the framebuffer with BG_COLOUR after reset.
module vga_scanout #(
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       plot,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  output logic       busy,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [9:0] VGA_R,
  output logic [9:0] VGA_G,
  output logic [9:0] VGA_B
);

  localparam int unsigned FB_WORDS = 19200;

  localparam logic [9:0] H_VIS = 10'd640;
  localparam logic [9:0] H_SS  = 10'd656;
  localparam logic [9:0] H_SE  = 10'd752;
  localparam logic [9:0] H_TOT = 10'd800;
  localparam logic [9:0] V_VIS = 10'd480;
  localparam logic [9:0] V_SS  = 10'd490;
  localparam logic [9:0] V_SE  = 10'd492;
  localparam logic [9:0] V_TOT = 10'd525;

  logic [2:0]  r_fb [0:FB_WORDS-1];

  logic        r_pix_en;
  logic [9:0]  r_hcount;
  logic [9:0]  r_vcount;

  logic        r_hs1;
  logic        r_vs1;
  logic        r_blank1;
  logic [2:0]  r_rd;

  logic        r_hs2;
  logic        r_vs2;
  logic        r_blank2;
  logic [2:0]  r_rgb;

  logic        w_plot_ok;
  logic [14:0] w_plot_addr;
  logic        w_we;
  logic [14:0] w_waddr;
  logic [2:0]  w_wdata;

  logic        w_vis;
  logic        w_hs;
  logic        w_vs;
  logic [14:0] w_row;
  logic [14:0] w_raddr;

  // y*160 + x as two shifts and an add
  assign w_plot_addr = {1'b0, y, 7'b0}
                     + {3'b0, y, 5'b0}
                     + {7'b0, x};
  assign w_plot_ok = plot
                   && (x < 8'd160)
                   && (y < 7'd120);

`ifdef SCANOUT_CLEAR_EN
  logic        r_busy;
  logic [14:0] r_clr_addr;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy     <= 1'b1;
      r_clr_addr <= '0;
    end else if (r_busy) begin
      if (r_clr_addr == 15'(FB_WORDS - 1))
        r_busy <= 1'b0;
      else
        r_clr_addr <= r_clr_addr + 15'd1;
    end
  end

  // Plots are simply dropped while the clear owns the write port
  assign busy    = r_busy;
  assign w_we    = r_busy ? ~reset : w_plot_ok;
  assign w_waddr = r_busy ? r_clr_addr : w_plot_addr;
  assign w_wdata = r_busy ? BG_COLOUR : colour;
`else
  assign busy    = 1'b0;
  assign w_we    = w_plot_ok;
  assign w_waddr = w_plot_addr;
  assign w_wdata = colour;
`endif

  always_ff @(posedge clock) begin
    if (w_we)
      r_fb[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pix_en <= 1'b0;
      r_hcount <= '0;
      r_vcount <= '0;
    end else begin
      r_pix_en <= ~r_pix_en;
      if (r_pix_en) begin
        if (r_hcount == H_TOT - 10'd1) begin
          r_hcount <= '0;
          if (r_vcount == V_TOT - 10'd1)
            r_vcount <= '0;
          else
            r_vcount <= r_vcount + 10'd1;
        end else begin
          r_hcount <= r_hcount + 10'd1;
        end
      end
    end
  end

  assign w_vis = (r_hcount < H_VIS) && (r_vcount < V_VIS);
  assign w_hs  = !((r_hcount >= H_SS) && (r_hcount < H_SE));
  assign w_vs  = !((r_vcount >= V_SS) && (r_vcount < V_SE));

  assign w_row   = {7'b0, r_vcount[9:2]};
  assign w_raddr = (w_row << 7)
                 + (w_row << 5)
                 + {7'b0, r_hcount[9:2]};

  // Read sees the pre-write contents when a plot hits the same word
  always_ff @(posedge clock) begin
    if (reset)
      r_rd <= '0;
    else if (r_pix_en && w_vis)
      r_rd <= r_fb[w_raddr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hs1    <= 1'b1;
      r_vs1    <= 1'b1;
      r_blank1 <= 1'b0;
      r_hs2    <= 1'b1;
      r_vs2    <= 1'b1;
      r_blank2 <= 1'b0;
      r_rgb    <= '0;
    end else if (r_pix_en) begin
      r_hs1    <= w_hs;
      r_vs1    <= w_vs;
      r_blank1 <= w_vis;
      r_hs2    <= r_hs1;
      r_vs2    <= r_vs1;
      r_blank2 <= r_blank1;
      r_rgb    <= r_blank1 ? r_rd : 3'b000;
    end
  end

  assign VGA_CLK     = r_pix_en;
  assign VGA_HS      = r_hs2;
  assign VGA_VS      = r_vs2;
  assign VGA_BLANK_N = r_blank2;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = {10{r_rgb[2]}};
  assign VGA_G       = {10{r_rgb[1]}};
  assign VGA_B       = {10{r_rgb[0]}};

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: timing/framebuffer model of the scanout plus pinned literal checks.
// Honours SCANOUT_CLEAR_EN for the busy/clear behaviour.
module tb_vga_scanout;

  localparam logic [2:0] BG = 3'b010;
`ifdef SCANOUT_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       plot = 1'b0;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic [2:0] colour = '0;
  logic       busy;
  logic       VGA_CLK;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic       VGA_SYNC_N;
  logic [9:0] VGA_R;
  logic [9:0] VGA_G;
  logic [9:0] VGA_B;

  always #10 clock = ~clock;

  vga_scanout #(.BG_COLOUR(BG)) dut (
    .clock(clock),
    .reset(reset),
    .plot(plot),
    .x(x),
    .y(y),
    .colour(colour),
    .busy(busy),
    .VGA_CLK(VGA_CLK),
    .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_R(VGA_R),
    .VGA_G(VGA_G),
    .VGA_B(VGA_B)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state: t = rising edges since reset was released (0 while in reset)
  int         t = 0;
  bit         m_live = 1'b0;
  logic [2:0] m_fb [0:19199];
  bit         m_known [0:19199];
  logic [2:0] m_rd = '0;
  bit         m_rd_ok = 1'b0;
  logic [2:0] m_disp = '0;
  bit         m_disp_ok = 1'b0;
  bit         m_busy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0d: got %h expected %h", nm, t, act, exp);
    end
  endtask

  task automatic wait_t(input int tgt, input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (t != tgt && k < 60000);
    if (t != tgt) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: timeout waiting for t=%0d (now %0d)", nm, tgt, t);
    end
  endtask

  task automatic do_plot(input int px, input int py, input logic [2:0] c);
    x = 8'(px);
    y = 7'(py);
    colour = c;
    plot = 1'b1;
  endtask

  // Screen position s (pixel-clock index) is read on edge 2(s+1) and shown from edge 2(s+2)
  always @(posedge clock) begin
    bit acc;
    int s;
    int h;
    int v;
    int a;
    acc = plot && (x < 160) && (y < 120) && !m_busy;
    if (reset) begin
      m_live = 1'b1;
      t = 0;
      m_rd = '0;
      m_rd_ok = 1'b1;
      m_disp = '0;
      m_disp_ok = 1'b1;
      m_busy = CLR;
    end else begin
      t++;
      if (t % 2 == 0) begin
        m_disp = m_rd;
        m_disp_ok = m_rd_ok;
        s = t / 2 - 1;
        h = s % 800;
        v = (s / 800) % 525;
        if (h < 640 && v < 480) begin
          a = (v / 4) * 160 + h / 4;
          m_rd = m_fb[a];
          m_rd_ok = m_known[a];
        end
      end
      if (CLR && t <= 19200) begin
        m_fb[t-1] = BG;
        m_known[t-1] = 1'b1;
      end
      m_busy = CLR && (t < 19200);
    end
    if (acc) begin
      a = int'(y) * 160 + int'(x);
      m_fb[a] = colour;
      m_known[a] = 1'b1;
    end
  end

  always @(negedge clock) begin
    if (m_live) begin
      int s;
      int h;
      int v;
      logic ehs;
      logic evs;
      logic eb;
      logic [2:0] ec;
      s = t / 2 - 2;
      ehs = 1'b1;
      evs = 1'b1;
      eb = 1'b0;
      ec = '0;
      if (s >= 0) begin
        h = s % 800;
        v = (s / 800) % 525;
        ehs = !(h >= 656 && h < 752);
        evs = !(v >= 490 && v < 492);
        eb = (h < 640 && v < 480);
        if (eb) ec = m_disp;
      end
      chk("vga_clk", VGA_CLK, (t % 2 == 1));
      chk("hs", VGA_HS, ehs);
      chk("vs", VGA_VS, evs);
      chk("blank_n", VGA_BLANK_N, eb);
      chk("sync_n", VGA_SYNC_N, 1'b0);
      chk("busy", busy, m_busy);
      if (!eb || m_disp_ok) begin
        chk("r", VGA_R, {10{ec[2]}});
        chk("g", VGA_G, {10{ec[1]}});
        chk("b", VGA_B, {10{ec[0]}});
      end
    end
  end

`ifndef SCANOUT_CLEAR_EN
  initial begin : literals
    wait_t(4, "px00");
    chk("px00_r", VGA_R, 10'h3FF);
    chk("px00_g", VGA_G, 10'h000);
    chk("px00_b", VGA_B, 10'h000);
    chk("px00_blank", VGA_BLANK_N, 1'b1);
    wait_t(10, "px30");
    chk("px30_r", VGA_R, 10'h3FF);
    wait_t(11, "clk_hi");
    chk("clk_hi", VGA_CLK, 1'b1);
    wait_t(28, "px12_0");
    chk("px12_0_g", VGA_G, 10'h3FF);
    chk("px12_0_r", VGA_R, 10'h000);
    wait_t(1283, "blank_end");
    chk("blank_last", VGA_BLANK_N, 1'b1);
    wait_t(1284, "blank_fp");
    chk("blank_fp", VGA_BLANK_N, 1'b0);
    wait_t(1315, "hs_pre");
    chk("hs_pre", VGA_HS, 1'b1);
    wait_t(1316, "hs_fall");
    chk("hs_fall", VGA_HS, 1'b0);
    wait_t(1507, "hs_last");
    chk("hs_last", VGA_HS, 1'b0);
    wait_t(1508, "hs_rise");
    chk("hs_rise", VGA_HS, 1'b1);
    wait_t(2915, "hs2_pre");
    chk("hs2_pre", VGA_HS, 1'b1);
    wait_t(2916, "hs2_fall");
    chk("hs2_fall", VGA_HS, 1'b0);
    wait_t(19364, "a500_old");
    chk("a500_old_g", VGA_G, 10'h3FF);
    chk("a500_old_r", VGA_R, 10'h000);
    wait_t(20964, "a500_new");
    chk("a500_new_r", VGA_R, 10'h3FF);
    chk("a500_new_g", VGA_G, 10'h000);
    chk("a500_new_b", VGA_B, 10'h3FF);
    wait_t(38404, "px960");
    chk("px960_r", VGA_R, 10'h3FF);
    chk("px960_g", VGA_G, 10'h000);
    chk("px960_b", VGA_B, 10'h000);
  end
`endif

  initial begin : stim
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_hs", VGA_HS, 1'b1);
    chk("rst_vs", VGA_VS, 1'b1);
    chk("rst_blank", VGA_BLANK_N, 1'b0);
    chk("rst_clk", VGA_CLK, 1'b0);
    chk("rst_r", VGA_R, 10'h000);
    chk("rst_busy", busy, CLR);
    reset = 1'b0;
    do_plot(0, 0, 3'b100);
    @(negedge clock);
    do_plot(3, 0, 3'b010);
    @(negedge clock);
    do_plot(159, 119, 3'b011);
    for (int py = 0; py < 15; py++) begin
      for (int px = 0; px < 160; px++) begin
        if (!(py == 0 && (px == 0 || px == 3))) begin
          @(negedge clock);
          do_plot(px, py, 3'((px + 2 * py) % 8));
        end
      end
    end
    @(negedge clock);
    do_plot(160, 5, 3'b111);
    @(negedge clock);
    do_plot(3, 120, 3'b111);
    @(negedge clock);
    plot = 1'b0;

    // Word 500 (x=20,y=3) is being read on edge 19362
    wait_t(19361, "a500_plot");
    do_plot(20, 3, 3'b101);
    @(negedge clock);
    plot = 1'b0;

    // Mid-line reset at hcount=300, vcount=30
    wait_t(48601, "mid_rst");
    reset = 1'b1;
    @(negedge clock);
    chk("mrst_hs", VGA_HS, 1'b1);
    chk("mrst_vs", VGA_VS, 1'b1);
    chk("mrst_blank", VGA_BLANK_N, 1'b0);
    chk("mrst_g", VGA_G, 10'h000);
    chk("mrst_clk", VGA_CLK, 1'b0);
    reset = 1'b0;
    wait_t(1315, "mrst_hs_pre");
    chk("mrst_hs_pre", VGA_HS, 1'b1);
    wait_t(1316, "mrst_hs_fall");
    chk("mrst_hs_fall", VGA_HS, 1'b0);
    wait_t(3300, "end");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
